// File: rtl/twiddle_fetch_pkg.sv
// Shared FFT definitions: fetch-state encoding, sizing constants and the
// radix-2 DIF twiddle address helper used by the fetch block and butterfly address gen.
package twiddle_fetch_pkg;

  localparam int FFT_ADDR_WIDTH = 5;
  localparam int FFT_DATA_WIDTH = 64;
  localparam int FFT_STG_WIDTH  = 3;
  localparam int HALF_N         = 2 ** (FFT_ADDR_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  // Stage s reuses the first N/2 >> s twiddles, each spaced 2**s apart.
  function automatic logic [FFT_ADDR_WIDTH-1:0] tw_addr(
    input logic [FFT_ADDR_WIDTH-1:0] b,
    input logic [FFT_STG_WIDTH-1:0]  stage
  );
    logic [FFT_ADDR_WIDTH-1:0] mask;
    mask = FFT_ADDR_WIDTH'(HALF_N >> stage) - FFT_ADDR_WIDTH'(1);
    return (b & mask) << stage;
  endfunction

endpackage

// File: rtl/twiddle_fetch_if.sv
// Twiddle word stream towards the butterfly unit: valid/ready with a last-word marker.
interface twiddle_fetch_if
  import twiddle_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH
);

  logic                  tw_valid;
  logic                  tw_ready;
  logic [DATA_WIDTH-1:0] tw_data;
  logic                  tw_last;

  modport master (
    output tw_valid,
    input  tw_ready,
    output tw_data,
    output tw_last
  );

  modport slave (
    input  tw_valid,
    output tw_ready,
    input  tw_data,
    input  tw_last
  );

endinterface

// File: rtl/twiddle_fetch.sv
// Twiddle ROM read controller for one FFT stage: start -> first word 2 cycles later, 1 word/cycle.
// Backpressure stalls the ROM enable so the ROM output register doubles as the only output buffer.
module twiddle_fetch
  import twiddle_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = FFT_ADDR_WIDTH,
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int STG_WIDTH  = FFT_STG_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [STG_WIDTH-1:0]  stage,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  twiddle_fetch_if.master       tw
);

  localparam logic [ADDR_WIDTH-1:0] B_LAST = ADDR_WIDTH'(HALF_N - 1);

  fetch_state_t          state_q, state_d;
  logic [STG_WIDTH-1:0]  stage_q;
  logic [ADDR_WIDTH-1:0] b_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  done_q;
  logic                  start_ok;
  logic                  issue;
  logic                  accept;

  assign start_ok = start && (32'(stage) < ADDR_WIDTH);
  assign accept   = valid_q && tw.tw_ready;
  // A new read may go out whenever the ROM output slot is empty or being drained this cycle.
  assign issue    = (state_q == ST_RUN) && (!valid_q || tw.tw_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_RUN;
      ST_RUN:   if (issue && (b_q == B_LAST)) state_d = ST_DRAIN;
      ST_DRAIN: if (accept && last_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && start_ok) begin
        stage_q <= stage;
        b_q     <= '0;
      end else if (issue) begin
        b_q <= b_q + 1'b1;
      end
      if (issue) begin
        valid_q <= 1'b1;
        last_q  <= (b_q == B_LAST);
      end else if (accept) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
      done_q <= (state_q == ST_DRAIN) && accept && last_q;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign rom_en      = issue;
  assign rom_addr    = tw_addr(b_q, stage_q);
  assign tw.tw_valid = valid_q;
  assign tw.tw_data  = rom_dout;
  assign tw.tw_last  = last_q;

endmodule

// File: tb/tb_twiddle_fetch.sv
// Randomized scoreboard bench for twiddle_fetch with a behavioural ROM holding word i = i.
module tb_twiddle_fetch;

  localparam int AW    = 5;
  localparam int DW    = 64;
  localparam int SW    = 3;
  localparam int HALFN = 16;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
    bit            first;
  } exp_t;

  logic          clock;
  logic          reset;
  logic          start;
  logic [SW-1:0] stage;
  logic          busy;
  logic          done;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;

  twiddle_fetch_if #(.DATA_WIDTH(DW)) tw ();

  twiddle_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STG_WIDTH(SW)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .stage    (stage),
    .busy     (busy),
    .done     (done),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .tw       (tw.master)
  );

  exp_t        q[$];
  int          first_q[$];
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  int          last_cyc = 0;
  int          start_cyc = 0;
  bit          rnd_ready = 0;
  bit          holding = 0;
  bit          prev_last = 0;
  logic [DW-1:0] held_data;
  logic        held_last;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc = cyc + 1;

  // Registered, enable-gated ROM: output holds while en is low.
  always @(posedge clock) if (rom_en) rom_dout <= DW'(rom_addr);

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: stage s visits addresses (b mod (N/2 / 2**s)) * 2**s for b = 0..N/2-1.
  task automatic push_run(input int s);
    exp_t e;
    int span;
    span = HALFN >> s;
    for (int b = 0; b < HALFN; b++) begin
      e.data  = DW'((b % span) * (1 << s));
      e.last  = (b == HALFN - 1);
      e.first = (b == 0);
      q.push_back(e);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      holding   = 0;
      prev_last = 0;
    end else begin
      if (prev_last || done) check("done_after_last", DW'(done), DW'(prev_last));
      prev_last = 0;
      if (holding && !tw.tw_valid) check("valid_dropped_while_stalled", 64'd0, 64'd1);
      if (tw.tw_valid) begin
        if (holding) begin
          check("stall_data_stable", tw.tw_data, held_data);
          check("stall_last_stable", DW'(tw.tw_last), DW'(held_last));
        end
        if (tw.tw_ready) begin
          acc_cnt++;
          holding = 0;
          if (q.size() == 0) begin
            check("unexpected_word", tw.tw_data, 64'hdead);
          end else begin
            e = q.pop_front();
            check("tw_data", tw.tw_data, e.data);
            check("tw_last", DW'(tw.tw_last), DW'(e.last));
            if (e.first) first_q.push_back(cyc);
            if (e.last) last_cyc = cyc;
            prev_last = e.last;
          end
        end else begin
          holding   = 1;
          held_data = tw.tw_data;
          held_last = tw.tw_last;
        end
      end else begin
        holding = 0;
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    tw.tw_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic do_start(input int s);
    start     = 1'b1;
    stage     = SW'(s);
    start_cyc = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == d0) check("done_timeout", 64'd0, 64'd1);
    tick();
  endtask

  task automatic run_stage(input int s, input bit rnd);
    push_run(s);
    rnd_ready = rnd;
    do_start(s);
    wait_done(rnd ? 600 : 100);
    exp_done++;
    rnd_ready = 0;
  endtask

  initial begin
    int d0;
    int n;
    int a0;
    reset = 1'b1;
    start = 1'b0;
    stage = '0;
    tw.tw_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", DW'(busy), 64'd0);
    check("rst_done", DW'(done), 64'd0);
    check("rst_rom_en", DW'(rom_en), 64'd0);
    check("rst_rom_addr", DW'(rom_addr), 64'd0);
    check("rst_tw_valid", DW'(tw.tw_valid), 64'd0);
    check("rst_tw_last", DW'(tw.tw_last), 64'd0);
    reset = 1'b0;
    tick();

    // Stage 0 at full throughput, with latency and contiguity checks.
    first_q.delete();
    run_stage(0, 0);
    check("first_word_latency", DW'(first_q[0] - start_cyc), 64'd2);
    check("sixteen_consecutive", DW'(last_cyc - first_q[0]), 64'd15);

    run_stage(2, 0);
    run_stage(4, 0);
    run_stage(1, 1);
    run_stage(3, 1);

    // Start with another stage during RUN must be ignored.
    push_run(1);
    do_start(1);
    repeat (3) tick();
    start = 1'b1;
    stage = 3'd3;
    tick();
    start = 1'b0;
    wait_done(100);
    exp_done++;

    // Out-of-range stage in IDLE.
    d0 = done_cnt;
    do_start(5);
    for (int i = 0; i < 4; i++) begin
      check("bad_stage_busy", DW'(busy), 64'd0);
      check("bad_stage_valid", DW'(tw.tw_valid), 64'd0);
      tick();
    end
    check("bad_stage_no_done", DW'(done_cnt), DW'(d0));

    // Reset after the 7th accept.
    push_run(0);
    a0 = acc_cnt;
    d0 = done_cnt;
    do_start(0);
    n = 0;
    while (acc_cnt - a0 < 7 && n < 100) begin
      tick();
      n++;
    end
    check("seven_accepts", DW'(acc_cnt - a0), 64'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    check("mid_rst_tw_valid", DW'(tw.tw_valid), 64'd0);
    check("mid_rst_busy", DW'(busy), 64'd0);
    check("mid_rst_rom_en", DW'(rom_en), 64'd0);
    repeat (5) tick();
    check("mid_rst_no_done", DW'(done_cnt), DW'(d0));
    run_stage(0, 0);

    // Start held through done: second stage chains straight on.
    first_q.delete();
    push_run(0);
    push_run(2);
    start = 1'b1;
    stage = 3'd0;
    tick();
    stage = 3'd2;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 100) begin
      tick();
      n++;
    end
    start = 1'b0;
    wait_done(100);
    exp_done += 2;
    check("chained_done_count", DW'(done_cnt - d0), 64'd2);
    if (first_q.size() == 2) check("chained_gap", DW'(first_q[1] - first_q[0]), 64'd18);
    else check("chained_runs_seen", DW'(first_q.size()), 64'd2);

    repeat (4) tick();
    check("total_done", DW'(done_cnt), DW'(exp_done));
    check("queue_empty", DW'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
